// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage definitions: widths, reset vector, HALT opcode and the
// prefetch queue entry layout.
package cpu_fetch_pkg;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam logic [AW-1:0] RESET_PC = 16'h0000;
  localparam logic [3:0] OPC_HALT = 4'hF;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc_next;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular FIFO of DEPTH entries (DEPTH a power of two). Flush is synchronous
// and wins over push/pop. Callers must not push when full or pop when empty.
module fetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [PW:0]   count_o,
  output logic [W-1:0]  head_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW:0]   count_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge Clk) begin
    if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage carries no reset; validity is tracked by count_q alone.
  always_ff @(posedge Clk) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to a 1-cycle-latency
// instruction memory, buffers returned words in a prefetch queue and hands
// {instr, pc+1} to decode under a valid/stall handshake.
// Optional build macro FETCH_HALT_DETECT_EN: stop fetching after a HALT opcode
// is received (halted output); when undefined, halted is always 0.
module fetch_unit #(
  parameter int            AW       = cpu_fetch_pkg::AW,
  parameter int            DW       = cpu_fetch_pkg::DW,
  parameter int            QDEPTH   = 2,
  parameter logic [AW-1:0] RESET_PC = cpu_fetch_pkg::RESET_PC
) (
  input  logic          Clk,
  input  logic          Rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [DW-1:0] imem_rdata,
  output logic          id_valid,
  output logic [DW-1:0] id_instr,
  output logic [AW-1:0] id_pc_next,
  input  logic          id_stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          halted
);

  import cpu_fetch_pkg::*;

  localparam int CW = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [DW-1:0] instr;
    logic [AW-1:0] pc_next;
  } entry_t;

  logic [AW-1:0] pc_q, pc_d;
  logic          epoch_q, epoch_d;
  logic          halted_q, halted_d;
  logic          inflight_q, inflight_d;
  logic          inflight_epoch_q, inflight_epoch_d;
  logic [AW-1:0] inflight_pc_next_q, inflight_pc_next_d;

  logic [CW-1:0] count;
  logic [CW:0]   occupancy;
  entry_t        head;
  entry_t        push_entry;
  logic          issue, push, pop, halt_push, q_flush;

  // A response only counts if it belongs to the current fetch stream; a
  // redirect or reset in the same cycle discards it along with the queue.
  assign push = Rst && !redirect && inflight_q && (inflight_epoch_q == epoch_q);
  assign pop  = Rst && !redirect && (count != '0) && !id_stall;

  // Slots already committed (queued + in flight), less the one leaving now.
  assign occupancy = {1'b0, count} + {{CW{1'b0}}, inflight_q} - {{CW{1'b0}}, pop};
  assign issue     = Rst && !redirect && !halted_q && (occupancy < (CW+1)'(QDEPTH));

`ifdef FETCH_HALT_DETECT_EN
  assign halt_push = push && (imem_rdata[DW-1 -: 4] == OPC_HALT);
`else
  assign halt_push = 1'b0;
`endif

  // Next-state for PC, epoch, halt and the in-flight read tag.
  always_comb begin
    pc_d               = pc_q;
    epoch_d            = epoch_q;
    halted_d           = halted_q;
    // A read issued while the HALT word lands is abandoned.
    inflight_d         = issue && !halt_push;
    inflight_epoch_d   = epoch_q;
    inflight_pc_next_d = pc_q + 1'b1;
    if (redirect) begin
      pc_d     = redirect_pc;
      epoch_d  = ~epoch_q;
      halted_d = 1'b0;
    end else begin
      if (issue)     pc_d     = pc_q + 1'b1;
      if (halt_push) halted_d = 1'b1;
    end
  end

  // Control state, reset synchronously when Rst is low.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pc_q       <= RESET_PC;
      epoch_q    <= 1'b0;
      halted_q   <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      halted_q   <= halted_d;
      inflight_q <= inflight_d;
    end
  end

  // In-flight tag payload; only meaningful while inflight_q is set.
  always_ff @(posedge Clk) begin
    inflight_epoch_q   <= inflight_epoch_d;
    inflight_pc_next_q <= inflight_pc_next_d;
  end

  assign q_flush    = !Rst || redirect;
  assign push_entry = '{instr: imem_rdata, pc_next: inflight_pc_next_q};

  fetch_queue #(
    .W     ($bits(entry_t)),
    .DEPTH (QDEPTH)
  ) u_queue (
    .Clk         (Clk),
    .flush_i     (q_flush),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .count_o     (count),
    .head_o      (head)
  );

  assign imem_req   = issue;
  assign imem_addr  = pc_q;
  assign id_valid   = Rst && (count != '0);
  assign id_instr   = id_valid ? head.instr   : '0;
  assign id_pc_next = id_valid ? head.pc_next : '0;
  assign halted     = halted_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// stall/redirect run scored against an in-order address-stream model.
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata = 16'h0;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc_next;
  logic        id_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0;
  logic        halted;

  always #5 Clk = ~Clk;

  fetch_unit dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc_next  (id_pc_next),
    .id_stall    (id_stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  int checks   = 0;
  int failures = 0;

  // Memory responder state and reference stream model.
  bit          pend_req  = 1'b0;
  logic [15:0] pend_addr = 16'h0;
  bit          halt_mode = 1'b0;
  logic [15:0] exp_addr  = 16'h0;
  bit          acc;
  logic [15:0] exp_i, exp_pn;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_mode && a == 16'h0003) return 16'hF000;
    return 16'h1000 + a;
  endfunction

  // One clock cycle: answer last cycle's read, apply inputs, sample outputs,
  // then advance the model (next address decode should receive).
  task automatic drive(input bit rst_n, input bit stall, input bit redir,
                       input logic [15:0] rpc);
    @(negedge Clk);
    imem_rdata  = pend_req ? mem_word(pend_addr) : 16'($urandom);
    Rst         = rst_n;
    id_stall    = stall;
    redirect    = redir;
    redirect_pc = rpc;
    #1;
    pend_req  = imem_req;
    pend_addr = imem_addr;
    acc    = rst_n && !redir && id_valid && !stall;
    exp_i  = mem_word(exp_addr);
    exp_pn = exp_addr + 16'd1;
    if (!rst_n)     exp_addr = 16'h0000;
    else if (redir) exp_addr = rpc;
    else if (acc)   exp_addr = exp_addr + 16'd1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 16'h0);
    drive(0, 1, 1, 16'h1234);
    checks += 5;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", imem_req); end
    if (id_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", id_valid); end
    if (id_instr !== 16'h0) begin failures++; $display("FAIL reset_instr got=%h want=0000", id_instr); end
    if (id_pc_next !== 16'h0) begin failures++; $display("FAIL reset_pcn got=%h want=0000", id_pc_next); end
    if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b want=0", halted); end
  endtask

  task automatic test_stream();
    for (int c = 0; c < 12; c++) begin
      drive(1, 0, 0, 16'h0);
      checks += 3;
      if (id_valid !== (c >= 2)) begin failures++; $display("FAIL stream_valid c=%0d got=%b want=%b", c, id_valid, (c >= 2)); end
      if (imem_req !== 1'b1) begin failures++; $display("FAIL stream_req c=%0d got=%b want=1", c, imem_req); end
      if (imem_addr !== 16'(c)) begin failures++; $display("FAIL stream_addr c=%0d got=%h want=%h", c, imem_addr, 16'(c)); end
      if (acc) begin
        checks++;
        if (id_instr !== exp_i || id_pc_next !== exp_pn) begin
          failures++; $display("FAIL stream_data got=%h/%h want=%h/%h", id_instr, id_pc_next, exp_i, exp_pn);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [15:0] a0;
    for (int c = 0; c < 5; c++) begin
      a0 = exp_addr;
      drive(1, 1, 0, 16'h0);
      checks += 3;
      if (id_valid !== 1'b1) begin failures++; $display("FAIL stall_valid c=%0d got=%b want=1", c, id_valid); end
      if (id_instr !== mem_word(a0) || id_pc_next !== a0 + 16'd1) begin
        failures++; $display("FAIL stall_hold c=%0d got=%h/%h want=%h/%h", c, id_instr, id_pc_next, mem_word(a0), a0 + 16'd1);
      end
      if (c >= 1 && imem_req !== 1'b0) begin failures++; $display("FAIL stall_req c=%0d got=%b want=0", c, imem_req); end
    end
    // Release: exactly two words are buffered, so the next fetch is head+2.
    a0 = exp_addr;
    drive(1, 0, 0, 16'h0);
    checks += 2;
    if (imem_req !== 1'b1 || imem_addr !== a0 + 16'd2) begin
      failures++; $display("FAIL stall_resume_addr got=%b/%h want=1/%h", imem_req, imem_addr, a0 + 16'd2);
    end
    if (!acc || id_instr !== exp_i || id_pc_next !== exp_pn) begin
      failures++; $display("FAIL stall_resume_data got=%h/%h want=%h/%h", id_instr, id_pc_next, exp_i, exp_pn);
    end
    for (int c = 0; c < 8; c++) begin
      drive(1, 0, 0, 16'h0);
      checks += 2;
      if (id_valid !== 1'b1) begin failures++; $display("FAIL stall_gap c=%0d got=%b want=1", c, id_valid); end
      if (id_instr !== exp_i || id_pc_next !== exp_pn) begin
        failures++; $display("FAIL stall_seq got=%h/%h want=%h/%h", id_instr, id_pc_next, exp_i, exp_pn);
      end
    end
  endtask

  task automatic test_redirect();
    drive(1, 0, 0, 16'h0);
    drive(1, 0, 1, 16'h0040);
    checks++;
    if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_req got=%b want=0", imem_req); end
    drive(1, 0, 0, 16'h0);
    checks += 2;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin failures++; $display("FAIL redir_addr got=%b/%h want=1/0040", imem_req, imem_addr); end
    if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_stale1 got=%b want=0", id_valid); end
    drive(1, 0, 0, 16'h0);
    checks++;
    if (id_valid !== 1'b0) begin failures++; $display("FAIL redir_stale2 got=%b want=0", id_valid); end
    drive(1, 0, 0, 16'h0);
    checks++;
    if (id_valid !== 1'b1 || id_instr !== 16'h1040 || id_pc_next !== 16'h0041) begin
      failures++; $display("FAIL redir_first got=%b/%h/%h want=1/1040/0041", id_valid, id_instr, id_pc_next);
    end
  endtask

  task automatic test_back_to_back();
    drive(1, 0, 1, 16'h0200);
    drive(1, 0, 1, 16'h0300);
    drive(1, 0, 0, 16'h0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0300) begin failures++; $display("FAIL b2b_addr got=%b/%h want=1/0300", imem_req, imem_addr); end
    drive(1, 0, 0, 16'h0);
    drive(1, 0, 0, 16'h0);
    checks++;
    if (id_valid !== 1'b1 || id_instr !== 16'h1300 || id_pc_next !== 16'h0301) begin
      failures++; $display("FAIL b2b_first got=%b/%h/%h want=1/1300/0301", id_valid, id_instr, id_pc_next);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want_pcn [3];
    want_pcn[0] = 16'hFFFF; want_pcn[1] = 16'h0000; want_pcn[2] = 16'h0001;
    drive(1, 0, 1, 16'hFFFE);
    drive(1, 0, 0, 16'h0);
    drive(1, 0, 0, 16'h0);
    for (int c = 0; c < 3; c++) begin
      drive(1, 0, 0, 16'h0);
      checks++;
      if (id_valid !== 1'b1 || id_pc_next !== want_pcn[c] || id_instr !== 16'(16'h0FFE + c)) begin
        failures++; $display("FAIL wrap c=%0d got=%b/%h/%h want=1/%h/%h", c, id_valid, id_instr, id_pc_next, 16'(16'h0FFE + c), want_pcn[c]);
      end
    end
  endtask

  task automatic test_halt();
    halt_mode = 1'b1;
    drive(0, 0, 0, 16'h0);
    for (int c = 0; c < 10; c++) begin
      drive(1, 0, 0, 16'h0);
`ifdef FETCH_HALT_DETECT_EN
      checks += 3;
      if (halted !== (c >= 5)) begin failures++; $display("FAIL halt_flag c=%0d got=%b want=%b", c, halted, (c >= 5)); end
      if (imem_req !== (c <= 4)) begin failures++; $display("FAIL halt_req c=%0d got=%b want=%b", c, imem_req, (c <= 4)); end
      if (id_valid !== (c >= 2 && c <= 5)) begin failures++; $display("FAIL halt_valid c=%0d got=%b want=%b", c, id_valid, (c >= 2 && c <= 5)); end
`else
      checks += 3;
      if (halted !== 1'b0) begin failures++; $display("FAIL nohalt_flag c=%0d got=%b want=0", c, halted); end
      if (imem_req !== 1'b1) begin failures++; $display("FAIL nohalt_req c=%0d got=%b want=1", c, imem_req); end
      if (id_valid !== (c >= 2)) begin failures++; $display("FAIL nohalt_valid c=%0d got=%b want=%b", c, id_valid, (c >= 2)); end
`endif
      if (acc) begin
        checks++;
        if (id_instr !== exp_i || id_pc_next !== exp_pn) begin
          failures++; $display("FAIL halt_data got=%h/%h want=%h/%h", id_instr, id_pc_next, exp_i, exp_pn);
        end
      end
    end
    drive(1, 0, 1, 16'h0010);
    drive(1, 0, 0, 16'h0);
    checks++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0010) begin
      failures++; $display("FAIL halt_resume got=%b/%b/%h want=0/1/0010", halted, imem_req, imem_addr);
    end
    drive(1, 0, 0, 16'h0);
    drive(1, 0, 0, 16'h0);
    checks++;
    if (id_valid !== 1'b1 || id_instr !== 16'h1010 || id_pc_next !== 16'h0011) begin
      failures++; $display("FAIL halt_resume_data got=%b/%h/%h want=1/1010/0011", id_valid, id_instr, id_pc_next);
    end
    halt_mode = 1'b0;
  endtask

  task automatic test_reset_full();
    for (int c = 0; c < 4; c++) drive(1, 1, 0, 16'h0);
    drive(0, 1, 0, 16'h0);
    checks++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || id_instr !== 16'h0 || id_pc_next !== 16'h0) begin
      failures++; $display("FAIL rstfull_during got=%b/%b/%h/%h want=0/0/0000/0000", imem_req, id_valid, id_instr, id_pc_next);
    end
    drive(1, 1, 0, 16'h0);
    checks++;
    if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      failures++; $display("FAIL rstfull_after got=%b/%b/%h want=0/1/0000", id_valid, imem_req, imem_addr);
    end
    drive(1, 0, 0, 16'h0);
    drive(1, 0, 0, 16'h0);
    checks++;
    if (id_valid !== 1'b1 || id_instr !== 16'h1000 || id_pc_next !== 16'h0001) begin
      failures++; $display("FAIL rstfull_first got=%b/%h/%h want=1/1000/0001", id_valid, id_instr, id_pc_next);
    end
  endtask

  task automatic test_random();
    int  n_acc = 0;
    bit  st, rd;
    logic [15:0] rpc;
    for (int c = 0; c < 400; c++) begin
      st  = ($urandom % 100) < 30;
      rd  = ($urandom % 100) < 5;
      rpc = 16'($urandom_range(0, 16'hDFF0));
      drive(1, st, rd, rpc);
      if (rd) begin
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL rand_redir_req c=%0d got=%b want=0", c, imem_req); end
      end
      if (acc) begin
        n_acc++;
        checks++;
        if (id_instr !== exp_i || id_pc_next !== exp_pn) begin
          failures++; $display("FAIL rand_data c=%0d got=%h/%h want=%h/%h", c, id_instr, id_pc_next, exp_i, exp_pn);
        end
      end
    end
    checks++;
    if (n_acc < 100) begin failures++; $display("FAIL rand_throughput got=%0d want>=100", n_acc); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_back_to_back();
    test_wrap();
    test_halt();
    test_reset_full();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
